// File: rtl/regfile_bus_arbiter.sv
// Round-robin arbiter that shares one register-file slave bus between
// several access agents. Each grant produces exactly one single-cycle bus
// access (IDLE -> ACCESS -> DONE) followed by a one-hot completion pulse.
module regfile_bus_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]            m_gnt,
  output logic [NUM_MASTERS-1:0]            m_done,
  output logic                              m_err,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [ADDR_WIDTH-1:0]             addr,
  output logic                              chip_select,
  output logic                              write_en,
  output logic                              read_en,
  output logic [DATA_WIDTH-1:0]             write_data,
  input  logic [DATA_WIDTH-1:0]             read_data,
  input  logic                              data_valid
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] pick;
  logic             pick_valid;
  logic             lat_we;
  logic             err_q;

  // Round-robin search starting at the pointer; the lowest rotated distance wins.
  always_comb begin
    int idx;
    pick       = ptr;
    pick_valid = 1'b0;
    idx        = 0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (m_req[idx[IDX_W-1:0]]) begin
        pick       = idx[IDX_W-1:0];
        pick_valid = 1'b1;
      end
    end
  end

  // State register; an asynchronous reset drops any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and pure state decode of all handshake and strobe outputs.
  always_comb begin
    state_next  = state;
    m_gnt       = '0;
    m_done      = '0;
    m_err       = 1'b0;
    chip_select = 1'b0;
    write_en    = 1'b0;
    read_en     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) state_next = ACCESS;
      end
      ACCESS: begin
        chip_select = 1'b1;
        write_en    = lat_we;
        read_en     = ~lat_we;
        m_gnt       = NUM_MASTERS'(1) << winner;
        state_next  = DONE;
      end
      DONE: begin
        m_gnt      = NUM_MASTERS'(1) << winner;
        m_done     = NUM_MASTERS'(1) << winner;
        m_err      = err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latching at the grant, read capture during the access, pointer advance on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      winner     <= '0;
      lat_we     <= 1'b0;
      err_q      <= 1'b0;
      addr       <= '0;
      write_data <= '0;
      m_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            winner     <= pick;
            lat_we     <= m_we[pick];
            addr       <= m_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
            write_data <= m_wdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        ACCESS: begin
          if (!lat_we) m_rdata <= read_data;
          err_q <= ~lat_we & ~data_valid;
        end
        DONE: begin
          ptr <= (winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
